dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory between two requesters:
//   master 0 = processor load/store path, master 1 = host loader/debug port.
//   Picks one master per cycle, drives the memory port combinationally, and
//   sends read data back to the master that issued the read.
//   Round-robin arbitration with a bounded burst, so neither master starves.
// PARAMETERS
//   ADDR_W      32  address width
//   DATA_W      32  data width
//   RD_LATENCY  1   cycles from mem_re to valid mem_rdata (>=1)
//   BURST       4   max consecutive grants to one master while the other waits (>=1)
// PORTS
//   clk        in   1       clock; all state updates on posedge
//   rst        in   1       synchronous reset, active-high
//   m0_req     in   1       master 0 access request (held until granted)
//   m0_we      in   1       1 = write, 0 = read
//   m0_addr    in   ADDR_W  master 0 address
//   m0_wdata   in   DATA_W  master 0 write data
//   m0_gnt     out  1       master 0 access accepted this cycle
//   m0_rvalid  out  1       master 0 read data valid
//   m0_rdata   out  DATA_W  master 0 read data
//   m1_*       -    -       same seven signals for master 1
//   mem_addr   out  ADDR_W  memory address
//   mem_wdata  out  DATA_W  memory write data
//   mem_we     out  1       memory write strobe
//   mem_re     out  1       memory read strobe
//   mem_rdata  in   DATA_W  memory read data
// BEHAVIOUR
//   State: owner {IDLE, OWN0, OWN1}; run (saturating at BURST);
//   last (last granted master); rd tag pipe (RD_LATENCY stages of {vld, id}).
//   Reset values: owner=IDLE, run=0, last=M1 (so M0 wins the first tie), tag pipe cleared.
//   While rst=1, every output is 0.
//   Winner (combinational, from registered state and this cycle's requests):
//     - Owner keeps the grant if req_owner && (run<BURST || !req_other).
//     - Otherwise, if both masters request, the winner is !last.
//     - Otherwise the single requester wins; with no requests, no winner.
//   gnt_x = (winner==x). Zero-latency grant: the access happens this cycle.
//   Memory port: mem_addr/mem_wdata come from the winner; mem_we = winner.we;
//   mem_re = winner && !winner.we. With no winner: all memory outputs 0, no strobe.
//   Registered update:
//     - owner <= OWNx for winner x, or IDLE if no winner.
//     - run <= (winner==owner) ? min(run+1, BURST) : 1; run <= 0 with no winner.
//     - last <= winner when a winner exists; otherwise last is held.
//   Transitions:
//     IDLE -> OWNx on a grant to x.
//     OWNx -> OWNx while x keeps winning.
//     OWNx -> OWNy when forced to yield, or when x drops its request while y requests.
//     OWNx -> IDLE when there are no requests.
//   Read return: a granted read pushes {1, id} into the tag pipe.
//     - m<id>_rvalid pulses for 1 cycle exactly RD_LATENCY cycles after the grant.
//     - m<id>_rdata = mem_rdata in that cycle; otherwise 0.
//     - Back-to-back reads (mixed masters) return in order, one per cycle.
//   Writes produce no rvalid.
//   Memory conflicts within a cycle are impossible: only one access per cycle.
//   Reset mid-operation flushes the tag pipe; no rvalid ever follows reset
//   for an access granted before it.
//   A request with no grant must be held stable by the master; the arbiter
//   stores no request.
// TESTING
//   1. rst, then only m1_req read 0x10 -> m1_gnt=1, mem_re=1, mem_addr=0x10 same cycle;
//      m1_rvalid=1 one cycle later with rdata=mem contents; m0_* all 0.
//   2. m0_req, m1_req held high from reset release (BURST=4) -> gnt sequence
//      M0,M0,M0,M0,M1,M1,M1,M1,M0; never both gnt in one cycle.
//   3. m0_req alone for 10 cycles -> m0_gnt=1 every cycle; run saturates at 4, no gaps.
//   4. Same cycle: m0 write 0xDEADBEEF@0x20 and m1 read @0x20 -> m0 granted first
//      (last=M1 after reset); m1 granted next cycle; m1_rdata=0xDEADBEEF.
//   5. m0 read granted, rst=1 next cycle -> m0_rvalid stays 0, all outputs 0 during rst.
//   6. RD_LATENCY=2, reads m0@0x4, m1@0x8, m0@0xC back-to-back ->
//      rvalids m0, m1, m0 on cycles t+2, t+3, t+4 with the matching data.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port data memory: round-robin with a bounded
// burst, zero-latency grant, and a tag pipe that routes read data back to its issuer.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int BURST      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int RUN_W = (BURST < 1) ? 1 : $clog2(BURST + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(BURST);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]            owner_q, owner_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic                  last_q, last_d;
  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0] tag_id_q, tag_id_d;

  logic req0, req1;
  logic win_vld, win_id, win_we;
  logic ret_vld, ret_id;

  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] r);
    return (r >= RUN_MAX) ? RUN_MAX : r + 1'b1;
  endfunction

  // Winner selection: reset masks both requests so every output idles while rst is high.
  always_comb begin
    req0    = m0_req & ~rst;
    req1    = m1_req & ~rst;
    win_vld = 1'b0;
    win_id  = 1'b0;
    if (owner_q == OWN0 && req0 && (run_q < RUN_MAX || !req1)) begin
      win_vld = 1'b1;
      win_id  = 1'b0;
    end else if (owner_q == OWN1 && req1 && (run_q < RUN_MAX || !req0)) begin
      win_vld = 1'b1;
      win_id  = 1'b1;
    end else if (req0 && req1) begin
      win_vld = 1'b1;
      win_id  = ~last_q;
    end else if (req0) begin
      win_vld = 1'b1;
      win_id  = 1'b0;
    end else if (req1) begin
      win_vld = 1'b1;
      win_id  = 1'b1;
    end
  end

  always_comb begin
    win_we    = win_id ? m1_we : m0_we;
    m0_gnt    = win_vld & ~win_id;
    m1_gnt    = win_vld &  win_id;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (win_vld) begin
      mem_addr  = win_id ? m1_addr  : m0_addr;
      mem_wdata = win_id ? m1_wdata : m0_wdata;
      mem_we    = win_we;
      mem_re    = ~win_we;
    end
  end

  always_comb begin
    owner_d = IDLE;
    run_d   = '0;
    last_d  = last_q;
    if (win_vld) begin
      owner_d = win_id ? OWN1 : OWN0;
      run_d   = (owner_d == owner_q) ? sat_inc(run_q) : RUN_W'(1);
      last_d  = win_id;
    end
    tag_vld_d    = tag_vld_q << 1;
    tag_vld_d[0] = mem_re;
    tag_id_d     = tag_id_q << 1;
    tag_id_d[0]  = win_id;
  end

  // Stage boundary: arbitration state and read-tag pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= IDLE;
      run_q     <= '0;
      last_q    <= 1'b1;
      tag_vld_q <= '0;
    end else begin
      owner_q   <= owner_d;
      run_q     <= run_d;
      last_q    <= last_d;
      tag_vld_q <= tag_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_id_q <= tag_id_d;
  end

  // Read return: the oldest tag marks which master owns this cycle's mem_rdata.
  always_comb begin
    ret_vld   = tag_vld_q[RD_LATENCY-1] & ~rst;
    ret_id    = tag_id_q[RD_LATENCY-1];
    m0_rvalid = ret_vld & ~ret_id;
    m1_rvalid = ret_vld &  ret_id;
    m0_rdata  = m0_rvalid ? mem_rdata : '0;
    m1_rdata  = m1_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (read latency 1 and 2) share stimulus;
// read returns are scoreboarded against a bench-side shadow memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;

  logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_we, a_mem_re;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_we, b_mem_re;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          due;
    bit          id;
    logic [31:0] data;
  } ret_t;

  ret_t        qa[$];
  ret_t        qb[$];
  logic [31:0] shadow [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1), .BURST(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
    .mem_re(a_mem_re), .mem_rdata(a_mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(2), .BURST(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .mem_re(b_mem_re), .mem_rdata(b_mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 | 32'(i << 2);
  endfunction

  // Memory models: fixed-latency read pipes, initialised on the first clock.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] a_rd0, b_rd0, b_rd1;
  bit          init_a = 1'b0, init_b = 1'b0;

  always @(posedge clk) begin
    if (!init_a) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
      init_a <= 1'b1;
    end else if (a_mem_we) begin
      mem_a[a_mem_addr[9:2]] <= a_mem_wdata;
    end
    a_rd0 <= a_mem_re ? mem_a[a_mem_addr[9:2]] : 32'h0BAD0BAD;
  end
  assign a_mem_rdata = a_rd0;

  always @(posedge clk) begin
    if (!init_b) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= init_word(i);
      init_b <= 1'b1;
    end else if (b_mem_we) begin
      mem_b[b_mem_addr[9:2]] <= b_mem_wdata;
    end
    b_rd0 <= b_mem_re ? mem_b[b_mem_addr[9:2]] : 32'h0BAD0BAD;
    b_rd1 <= b_rd0;
  end
  assign b_mem_rdata = b_rd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, want %h", tag, cyc, got, exp);
    end
  endtask

  // Return monitor: every cycle each instance must show exactly the scoreboard head, or nothing.
  ret_t ra, rb;
  bit   ra_v, rb_v;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_a", 32'(|{a_m0_gnt, a_m0_rvalid, a_m0_rdata, a_m1_gnt, a_m1_rvalid,
                              a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_we, a_mem_re}), 32'd0);
      check("rst_out_b", 32'(|{b_m0_gnt, b_m0_rvalid, b_m0_rdata, b_m1_gnt, b_m1_rvalid,
                              b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_we, b_mem_re}), 32'd0);
    end else begin
      ra_v = 1'b0;
      rb_v = 1'b0;
      if (qa.size() > 0 && qa[0].due == cyc) begin
        ra = qa.pop_front();
        ra_v = 1'b1;
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
        rb = qb.pop_front();
        rb_v = 1'b1;
      end
      check("rvalid_a", 32'({a_m1_rvalid, a_m0_rvalid}),
            32'(ra_v ? (ra.id ? 2'b10 : 2'b01) : 2'b00));
      check("rdata0_a", a_m0_rdata, (ra_v && !ra.id) ? ra.data : 32'd0);
      check("rdata1_a", a_m1_rdata, (ra_v &&  ra.id) ? ra.data : 32'd0);
      check("rvalid_b", 32'({b_m1_rvalid, b_m0_rvalid}),
            32'(rb_v ? (rb.id ? 2'b10 : 2'b01) : 2'b00));
      check("rdata0_b", b_m0_rdata, (rb_v && !rb.id) ? rb.data : 32'd0);
      check("rdata1_b", b_m1_rdata, (rb_v &&  rb.id) ? rb.data : 32'd0);
    end
  end

  task automatic drv0(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
  endtask

  task automatic drv1(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
  endtask

  // One cycle with the expected winner: scoreboard push, then grant/memory-port checks.
  task automatic tick(input bit eg0, input bit eg1);
    logic [31:0] ea, ed;
    logic        ewe, ere;
    ret_t        r;
    ea = '0; ed = '0; ewe = 1'b0; ere = 1'b0;
    if (eg0) begin
      ea = m0_addr; ed = m0_wdata; ewe = m0_we; ere = ~m0_we;
    end else if (eg1) begin
      ea = m1_addr; ed = m1_wdata; ewe = m1_we; ere = ~m1_we;
    end
    if (ewe) shadow[ea[9:2]] = ed;
    if (ere) begin
      r.id   = eg1;
      r.data = shadow[ea[9:2]];
      r.due  = cyc + 1;
      qa.push_back(r);
      r.due  = cyc + 2;
      qb.push_back(r);
    end
    @(negedge clk);
    check("gnt_a",      32'({a_m1_gnt, a_m0_gnt}), 32'({eg1, eg0}));
    check("gnt_b",      32'({b_m1_gnt, b_m0_gnt}), 32'({eg1, eg0}));
    check("mem_ctl_a",  32'({a_mem_we, a_mem_re}), 32'({ewe, ere}));
    check("mem_ctl_b",  32'({b_mem_we, b_mem_re}), 32'({ewe, ere}));
    check("mem_addr_a", a_mem_addr, ea);
    check("mem_addr_b", b_mem_addr, ea);
    check("mem_wd_a",   a_mem_wdata, ed);
    check("mem_wd_b",   b_mem_wdata, ed);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    repeat (n) tick(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, '0, '0);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    do_reset(2);

    // Single m1 read after reset.
    drv1(1'b1, 1'b0, 32'h10, '0);
    tick(1'b0, 1'b1);
    idle(3);

    // Both masters requesting continuously from reset release.
    do_reset(1);
    drv0(1'b1, 1'b0, 32'h40, '0);
    drv1(1'b1, 1'b0, 32'h80, '0);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    idle(3);

    // m0 alone for 10 writes, then a saturated run must yield to m1.
    for (int i = 0; i < 10; i++) begin
      drv0(1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
      tick(1'b1, 1'b0);
    end
    drv0(1'b1, 1'b1, 32'h128, 32'h100A);
    drv1(1'b1, 1'b0, 32'h104, '0);
    tick(1'b0, 1'b1);
    drv1(1'b0, 1'b0, '0, '0);
    tick(1'b1, 1'b0);
    idle(3);

    // Write/read collision on the same address.
    do_reset(1);
    drv0(1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
    drv1(1'b1, 1'b0, 32'h20, '0);
    tick(1'b1, 1'b0);
    drv0(1'b0, 1'b0, '0, '0);
    tick(1'b0, 1'b1);
    idle(3);

    // Reset right after a granted read, with requests still asserted.
    do_reset(1);
    drv0(1'b1, 1'b0, 32'h30, '0);
    tick(1'b1, 1'b0);
    drv1(1'b1, 1'b0, 32'h34, '0);
    do_reset(1);
    idle(4);

    // Back-to-back mixed-master reads.
    do_reset(1);
    drv0(1'b1, 1'b0, 32'h4, '0);
    tick(1'b1, 1'b0);
    drv0(1'b0, 1'b0, '0, '0);
    drv1(1'b1, 1'b0, 32'h8, '0);
    tick(1'b0, 1'b1);
    drv1(1'b0, 1'b0, '0, '0);
    drv0(1'b1, 1'b0, 32'hC, '0);
    tick(1'b1, 1'b0);
    idle(4);

    check("pending_a", 32'(qa.size()), 32'd0);
    check("pending_b", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
